one_to_two_distributor: RTL and testbench

//   Inverse of the 2-to-1 datapath selector: steers one 32-bit producer stream to one of
//   two consumers, chosen per word by Control (0 -> Zero port, 1 -> One port).

---
 rtl/one_to_two_distributor.sv | 117 +++++++++++
 tb/tb_one_to_two_distributor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/one_to_two_distributor.sv
// Steers one producer word stream to one of two consumers, each behind its own
// small FIFO, so a stalled consumer only holds back words destined for it.

module distributor_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [CW-1:0]    count
);
    localparam int PW = CW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop;

    // Caller guarantees push is never raised while full; pop is ignored when empty.
    always_comb begin
        pop      = pop_ready && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign count = count_q;
endmodule

module one_to_two_distributor #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [WIDTH-1:0] DataInput,
    input  logic             Control,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] ZeroOutput,
    output logic             ZeroValid,
    input  logic             ZeroReady,
    output logic [WIDTH-1:0] OneOutput,
    output logic             OneValid,
    input  logic             OneReady,
    output logic [CW-1:0]    ZeroCount,
    output logic [CW-1:0]    OneCount
);
    logic accept;
    logic push_zero;
    logic push_one;

    // Readiness looks only at the selected FIFO's registered count, never at consumer ready.
    always_comb begin
        InReady   = Control ? (OneCount != CW'(DEPTH)) : (ZeroCount != CW'(DEPTH));
        accept    = InValid && InReady;
        push_zero = accept && !Control;
        push_one  = accept && Control;
    end

    distributor_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_zero_fifo (
        .clk       (CLK),
        .rst_n     (RST_n),
        .push      (push_zero),
        .push_data (DataInput),
        .pop_ready (ZeroReady),
        .head      (ZeroOutput),
        .valid     (ZeroValid),
        .count     (ZeroCount)
    );

    distributor_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_one_fifo (
        .clk       (CLK),
        .rst_n     (RST_n),
        .push      (push_one),
        .push_data (DataInput),
        .pop_ready (OneReady),
        .head      (OneOutput),
        .valid     (OneValid),
        .count     (OneCount)
    );
endmodule

// File: tb/tb_one_to_two_distributor.sv
// Scoreboard bench: stimulus enqueues accepted words per destination, a negedge
// monitor checks occupancy, readiness and every popped word against those queues.

module tb_one_to_two_distributor;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             RST_n;
    logic [WIDTH-1:0] DataInput;
    logic             Control;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] ZeroOutput;
    logic             ZeroValid;
    logic             ZeroReady;
    logic [WIDTH-1:0] OneOutput;
    logic             OneValid;
    logic             OneReady;
    logic [CW-1:0]    ZeroCount;
    logic [CW-1:0]    OneCount;

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] zero_q[$];
    logic [WIDTH-1:0] one_q[$];

    logic             pend_valid = 1'b0;
    logic             pend_ctrl = 1'b0;
    logic [WIDTH-1:0] pend_data = '0;

    one_to_two_distributor #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .DataInput  (DataInput),
        .Control    (Control),
        .InValid    (InValid),
        .InReady    (InReady),
        .ZeroOutput (ZeroOutput),
        .ZeroValid  (ZeroValid),
        .ZeroReady  (ZeroReady),
        .OneOutput  (OneOutput),
        .OneValid   (OneValid),
        .OneReady   (OneReady),
        .ZeroCount  (ZeroCount),
        .OneCount   (OneCount)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // One producer cycle: commit last cycle's accepted word to the model, then drive the next.
    task automatic applyStimulus(input logic v, input logic c, input logic [WIDTH-1:0] d,
                                 input logic zr, input logic orr);
        bit room;
        @(posedge CLK);
        #1;
        if (pend_valid) begin
            if (pend_ctrl) one_q.push_back(pend_data);
            else           zero_q.push_back(pend_data);
        end
        InValid   = v;
        Control   = c;
        DataInput = d;
        ZeroReady = zr;
        OneReady  = orr;
        room       = c ? (one_q.size() < DEPTH) : (zero_q.size() < DEPTH);
        pend_valid = v && room;
        pend_ctrl  = c;
        pend_data  = d;
    endtask

    // Mid-cycle monitor: the queues hold exactly what the FIFOs should hold before the next edge.
    always @(negedge CLK) begin
        if (RST_n === 1'b1) begin
            checkOutput("zero_count", 32'(ZeroCount), 32'(zero_q.size()));
            checkOutput("one_count",  32'(OneCount),  32'(one_q.size()));
            checkOutput("zero_valid", 32'(ZeroValid), 32'(zero_q.size() != 0));
            checkOutput("one_valid",  32'(OneValid),  32'(one_q.size() != 0));
            checkOutput("in_ready",   32'(InReady),
                        32'(Control ? (one_q.size() < DEPTH) : (zero_q.size() < DEPTH)));
            if (ZeroValid && ZeroReady) begin
                if (zero_q.size() == 0) checkOutput("zero_underflow", ZeroOutput, 32'hxxxx_xxxx);
                else checkOutput("zero_data", ZeroOutput, zero_q.pop_front());
            end
            if (OneValid && OneReady) begin
                if (one_q.size() == 0) checkOutput("one_underflow", OneOutput, 32'hxxxx_xxxx);
                else checkOutput("one_data", OneOutput, one_q.pop_front());
            end
        end
    end

    initial begin
        int tries;
        RST_n     = 1'b0;
        InValid   = 1'b0;
        Control   = 1'b0;
        DataInput = '0;
        ZeroReady = 1'b0;
        OneReady  = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(InReady), 32'd1);
        checkOutput("rst_zero_valid", 32'(ZeroValid), 32'd0);
        checkOutput("rst_one_valid", 32'(OneValid), 32'd0);
        #12;
        RST_n = 1'b1;

        $display("[TB] single route");
        applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] fill, block and drain");
        applyStimulus(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] simultaneous push and pop");
        applyStimulus(1'b1, 1'b0, 32'h100, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h101, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] alternating stream");
        for (int i = 0; i < 16; i++) begin
            tries = 0;
            do begin
                applyStimulus(1'b1, 1'(i), 32'h10 + 32'(i), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)));
                tries++;
            end while (!pend_valid && tries < 50);
            if (!pend_valid) checkOutput("stream_accept_timeout", 32'(tries), 32'd0);
        end
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("stream_zero_left", 32'(zero_q.size()), 32'd0);
        checkOutput("stream_one_left", 32'(one_q.size()), 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom(),
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("[TB] asynchronous reset with both FIFOs occupied");
        applyStimulus(1'b1, 1'b0, 32'hCAFE0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hCAFE0001, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        RST_n = 1'b0;
        #1;
        checkOutput("arst_zero_valid", 32'(ZeroValid), 32'd0);
        checkOutput("arst_one_valid", 32'(OneValid), 32'd0);
        checkOutput("arst_zero_count", 32'(ZeroCount), 32'd0);
        checkOutput("arst_one_count", 32'(OneCount), 32'd0);
        checkOutput("arst_zero_out", ZeroOutput, 32'd0);
        checkOutput("arst_one_out", OneOutput, 32'd0);
        checkOutput("arst_in_ready", 32'(InReady), 32'd1);
        zero_q.delete();
        one_q.delete();
        pend_valid = 1'b0;
        @(posedge CLK);
        #3;
        RST_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        @(posedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
